axi_wr_xfer_engine: RTL and testbench
=====================================

Name: axi_wr_xfer_engine

Overview:
- Downstream of the 8-way submaster write arbiter.
- Accepts the one-cycle grant pulse, latches the granted submaster's address and burst length, and runs one AXI write burst (AW, W, B) on the shared master port.
- Streams write data from the granted submaster with a valid/ready handshake.
- Returns a one-cycle per-submaster xfer_done pulse, which releases the arbiter back to idle.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (32/64/128); awsize = log2(DATA_W/8)

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
grant  in  8  one-hot grant pulses from arbiter (bit i = submaster i)
req_addr_flat  in  8*ADDR_W  start address per submaster, slice i
req_len_flat  in  64  burst length per submaster, AXI encoding (beats-1), slice i
sm_wdata_flat  in  8*DATA_W  write data per submaster, slice i
sm_wvalid  in  8  per-submaster data valid
sm_wready  out  8  per-submaster data ready (only granted bit can be 1)
xfer_done  out  8  one-cycle completion pulse, bit i
xfer_err  out  8  asserted with xfer_done when bresp[1]=1
busy  out  1  high from grant latch until done pulse
awaddr/awlen/awsize/awburst/awid/awvalid  out  ADDR_W/8/3/2/3/1
awready  in  1
wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1
wready  in  1
bid  in  3;  bresp  in  2;  bvalid  in  1;  bready  out  1

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0; latched index 0. Reset mid-burst aborts immediately with no xfer_done pulse. Outstanding AXI beats are lost; the interconnect is reset together with this block.
- States: IDLE, ADDR, DATA, RESP, DONE.
- IDLE: if grant != 0, latch idx = lowest set bit of grant, addr = slice idx, len = slice idx. Go to ADDR next cycle. Multi-hot grant is illegal, and lowest index wins. busy=1 from the cycle after the grant.
- ADDR: awvalid=1, awaddr=addr, awlen=len, awsize=log2(DATA_W/8), awburst=2'b01 (INCR), awid=idx. Outputs are stable until awready. On awvalid&awready go to DATA and clear the beat counter.
- DATA: wvalid = sm_wvalid[idx]; sm_wready[idx] = wready; all other sm_wready bits are 0. wdata = sm_wdata_flat slice idx; wstrb all ones.
  - wlast = (beat_cnt == len).
  - Each wvalid&wready handshake increments beat_cnt (8-bit, no wrap possible since len ≤ 255).
  - A handshake with wlast moves to RESP.
  - W never starts before the AW handshake completes.
- RESP: bready=1. On bvalid, latch bresp and go to DONE. A bid != idx is also flagged as an error.
- DONE: for one cycle, xfer_done[idx]=1 and xfer_err[idx] = bresp[1] | id_mismatch. busy drops and the state returns to IDLE. The earliest new grant is accepted in the following IDLE cycle.
- Grant asserted in any non-IDLE state is ignored (no latch, no side effects).
- Minimum latency from grant to xfer_done for len=0 with all readies high: 5 cycles (latch, AW, W, B, DONE). The arbiter is already in its wait state by the time done arrives.
- Address alignment and 4KB-boundary compliance are the submaster's responsibility; the block does not check them.

Test Plan:
- Grant=8'h01, addr=0x1000, len=0, awready/wready/bvalid tied high, bresp=0 -> awaddr 0x1000/awlen 0/awid 0, one beat with wlast=1, xfer_done=8'h01 exactly 5 cycles after grant, xfer_err=0.
- Grant=8'h20 (PCIe), len=3, wready toggles 1-0-1-0, sm_wvalid[5] stalls one cycle -> exactly 4 W beats, wlast only on 4th, sm_wready only bit 5 active, awid=5, xfer_done=8'h20.
- awready delayed 6 cycles -> awaddr/awlen held stable, wvalid stays 0 until AW handshake.
- bresp=2'b10 (SLVERR) for grant=8'h80 -> xfer_done=8'h80 and xfer_err=8'h80 in the same cycle; separately, bid=2 for idx 7 -> xfer_err=8'h80.
- Grant pulse 8'h04 arriving during DATA of an idx-1 burst -> ignored; only xfer_done=8'h02 is produced, and no AW for idx 2.
- reset asserted mid-DATA at beat 2 of 4 -> all outputs 0 asynchronously, no xfer_done; after release, grant=8'h01 runs a clean burst.

Source files
------------

// File: rtl/axi_wr_xfer_engine.sv
// Single-burst AXI write engine behind the 8-way submaster arbiter: latches the granted
// submaster's request, runs AW/W/B on the shared master port, then pulses xfer_done for it.
module axi_wr_xfer_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            grant,
  input  logic [8*ADDR_W-1:0]   req_addr_flat,
  input  logic [63:0]           req_len_flat,
  input  logic [8*DATA_W-1:0]   sm_wdata_flat,
  input  logic [7:0]            sm_wvalid,
  output logic [7:0]            sm_wready,
  output logic [7:0]            xfer_done,
  output logic [7:0]            xfer_err,
  output logic                  busy,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [2:0]            awid,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [2:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);
  localparam logic [2:0] AWSIZE = 3'($clog2(DATA_W/8));

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic                berr_q, berr_d;
  logic [2:0]          sel;
  logic                w_hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    berr_d    = berr_q;
    sm_wready = '0;
    xfer_done = '0;
    xfer_err  = '0;
    busy      = (state_q != IDLE);
    awaddr    = '0;
    awlen     = '0;
    awsize    = '0;
    awburst   = '0;
    awid      = '0;
    awvalid   = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wlast     = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    w_hs      = 1'b0;

    // Multi-hot grant is illegal; resolve it to the lowest index anyway.
    sel = '0;
    for (int i = 7; i >= 0; i--)
      if (grant[i]) sel = 3'(i);

    unique case (state_q)
      IDLE: if (|grant) begin
        idx_d   = sel;
        addr_d  = req_addr_flat[sel*ADDR_W +: ADDR_W];
        len_d   = req_len_flat[sel*8 +: 8];
        state_d = ADDR;
      end
      ADDR: begin
        awvalid = 1'b1;
        awaddr  = addr_q;
        awlen   = len_q;
        awsize  = AWSIZE;
        awburst = 2'b01;
        awid    = idx_q;
        if (awready) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        wvalid           = sm_wvalid[idx_q];
        sm_wready[idx_q] = wready;
        wdata            = sm_wdata_flat[idx_q*DATA_W +: DATA_W];
        wstrb            = '1;
        wlast            = (beat_q == len_q);
        w_hs             = sm_wvalid[idx_q] & wready;
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (beat_q == len_q) state_d = RESP;
        end
      end
      RESP: begin
        bready = 1'b1;
        // A response carrying another master's id is treated as a failed transfer.
        if (bvalid) begin
          berr_d  = bresp[1] | (bid != idx_q);
          state_d = DONE;
        end
      end
      DONE: begin
        xfer_done[idx_q] = 1'b1;
        xfer_err[idx_q]  = berr_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_wr_xfer_engine.sv
// Directed bench for axi_wr_xfer_engine: scripted bursts with a cycle-level monitor,
// each scenario task compares the monitor's findings against hand-derived values.
module tb_axi_wr_xfer_engine;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  grant;
  logic [255:0] req_addr_flat;
  logic [63:0] req_len_flat;
  logic [255:0] sm_wdata_flat;
  logic [7:0]  sm_wvalid, sm_wready, xfer_done, xfer_err;
  logic        busy;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awid, bid;
  logic [1:0]  awburst, bresp;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready;

  logic [31:0] a_tb [8];
  logic [7:0]  l_tb [8];

  int vectors = 0;
  int miscompares = 0;

  // knobs
  int k_toggle, k_stall, k_aw_delay, k_glitch_cyc;
  logic [7:0] k_glitch;
  logic [1:0] k_bresp;
  logic [2:0] k_bid;

  // monitor results
  logic [7:0] m_done, m_err, m_awids;
  int m_cyc, m_beats, m_aw_cycles;
  bit m_wlast_bad, m_bad_sm, m_aw_bad, m_w_early, m_wdata_bad, m_busy_bad;

  axi_wr_xfer_engine #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .grant(grant),
    .req_addr_flat(req_addr_flat), .req_len_flat(req_len_flat),
    .sm_wdata_flat(sm_wdata_flat), .sm_wvalid(sm_wvalid), .sm_wready(sm_wready),
    .xfer_done(xfer_done), .xfer_err(xfer_err), .busy(busy),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      req_addr_flat[i*32 +: 32] = a_tb[i];
      req_len_flat[i*8 +: 8]    = l_tb[i];
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_defaults();
    k_toggle = 0; k_stall = 0; k_aw_delay = 0; k_glitch_cyc = 0;
    k_glitch = 8'h00; k_bresp = 2'b00; k_bid = 3'd0;
  endtask

  // Drives one burst from the grant cycle (cycle 1) and records what the master port did.
  // Returns when xfer_done is seen, when abort_beats handshakes are pending, or after 80 cycles.
  task automatic run_burst(input logic [7:0] g, input int abort_beats);
    int idx;
    bit aw_done;
    idx = 0;
    for (int i = 7; i >= 0; i--) if (g[i]) idx = i;
    m_done = 0; m_err = 0; m_awids = 0; m_cyc = 0; m_beats = 0; m_aw_cycles = 0;
    m_wlast_bad = 0; m_bad_sm = 0; m_aw_bad = 0; m_w_early = 0; m_wdata_bad = 0; m_busy_bad = 0;
    aw_done = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      grant     = (cyc == 1) ? g : ((cyc == k_glitch_cyc) ? k_glitch : 8'h00);
      awready   = (cyc >= 2 + k_aw_delay);
      wready    = (k_toggle != 0) ? (cyc % 2 == 1) : 1'b1;
      sm_wvalid = 8'hFF;
      if (cyc == k_stall) sm_wvalid[idx] = 1'b0;
      for (int i = 0; i < 8; i++)
        sm_wdata_flat[i*32 +: 32] = 32'hD000_0000 | (i << 16) | m_beats;
      bvalid = 1'b1; bresp = k_bresp; bid = k_bid;
      #1;
      if (cyc >= 2 && !busy) m_busy_bad = 1;
      if (xfer_done != 8'h00) begin
        m_done = xfer_done; m_err = xfer_err; m_cyc = cyc;
        break;
      end
      if (awvalid) begin
        m_aw_cycles++;
        m_awids |= 8'(1) << awid;
        if (awaddr !== a_tb[idx] || awlen !== l_tb[idx] || awsize !== 3'd2 || awburst !== 2'b01)
          m_aw_bad = 1;
      end
      if (wvalid && !aw_done) m_w_early = 1;
      if (awvalid && awready) aw_done = 1;
      if ((sm_wready & ~g) != 8'h00) m_bad_sm = 1;
      if (wvalid && wready) begin
        if (wdata !== (32'hD000_0000 | (idx << 16) | m_beats) || wstrb !== 4'hF) m_wdata_bad = 1;
        m_beats++;
        if (wlast !== (m_beats == int'(l_tb[idx]) + 1)) m_wlast_bad = 1;
      end
      if (abort_beats > 0 && m_beats == abort_beats) break;
      @(posedge clk); #0;
    end
    grant = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1; grant = 8'h01; awready = 1; wready = 1; bvalid = 1; bresp = 0; bid = 0;
    sm_wvalid = 8'hFF; sm_wdata_flat = '0;
    repeat (3) step();
    vectors++; if (xfer_done !== 8'h00) begin miscompares++; $display("FAIL reset_done got %h want 00", xfer_done); end
    vectors++; if (busy !== 1'b0 || awvalid !== 1'b0) begin miscompares++; $display("FAIL reset_busy_aw got %b%b want 00", busy, awvalid); end
    vectors++; if (wvalid !== 1'b0 || bready !== 1'b0 || sm_wready !== 8'h00) begin miscompares++; $display("FAIL reset_w got %b %b %h want 0 0 00", wvalid, bready, sm_wready); end
    vectors++; if (awaddr !== 32'h0 || xfer_err !== 8'h00) begin miscompares++; $display("FAIL reset_addr got %h %h want 0 0", awaddr, xfer_err); end
    grant = 8'h00;
    @(posedge clk); #1 reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    set_defaults();
    a_tb[0] = 32'h0000_1000; l_tb[0] = 8'd0;
    run_burst(8'h01, 0);
    vectors++; if (m_cyc !== 5) begin miscompares++; $display("FAIL basic_latency got %0d want 5", m_cyc); end
    vectors++; if (m_done !== 8'h01 || m_err !== 8'h00) begin miscompares++; $display("FAIL basic_done got %h/%h want 01/00", m_done, m_err); end
    vectors++; if (m_beats !== 1 || m_wlast_bad) begin miscompares++; $display("FAIL basic_beats got %0d wlast_bad=%0d want 1/0", m_beats, m_wlast_bad); end
    vectors++; if (m_awids !== 8'h01 || m_aw_bad || m_wdata_bad || m_busy_bad) begin miscompares++; $display("FAIL basic_aw got ids=%h bad=%0d%0d%0d want 01 000", m_awids, m_aw_bad, m_wdata_bad, m_busy_bad); end
    step();
    vectors++; if (xfer_done !== 8'h00 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_after got %h %b want 00 0", xfer_done, busy); end
  endtask

  task automatic test_stall_data();
    set_defaults();
    k_toggle = 1; k_stall = 5;
    a_tb[5] = 32'h0000_2000; l_tb[5] = 8'd3;
    run_burst(8'h20, 0);
    vectors++; if (m_beats !== 4 || m_wlast_bad) begin miscompares++; $display("FAIL stall_beats got %0d wlast_bad=%0d want 4/0", m_beats, m_wlast_bad); end
    vectors++; if (m_bad_sm || m_wdata_bad) begin miscompares++; $display("FAIL stall_smready got stray=%0d wdata_bad=%0d want 0/0", m_bad_sm, m_wdata_bad); end
    vectors++; if (m_awids !== 8'h20) begin miscompares++; $display("FAIL stall_awid got %h want 20", m_awids); end
    vectors++; if (m_done !== 8'h20 || m_cyc !== 13) begin miscompares++; $display("FAIL stall_done got %h@%0d want 20@13", m_done, m_cyc); end
    step();
  endtask

  task automatic test_aw_delay();
    set_defaults();
    k_aw_delay = 6;
    a_tb[0] = 32'h0000_3000; l_tb[0] = 8'd1;
    run_burst(8'h01, 0);
    vectors++; if (m_aw_cycles !== 7 || m_aw_bad) begin miscompares++; $display("FAIL awdly_hold got %0d cycles bad=%0d want 7/0", m_aw_cycles, m_aw_bad); end
    vectors++; if (m_w_early) begin miscompares++; $display("FAIL awdly_wearly got 1 want 0"); end
    vectors++; if (m_done !== 8'h01 || m_cyc !== 12 || m_beats !== 2) begin miscompares++; $display("FAIL awdly_done got %h@%0d beats=%0d want 01@12 beats=2", m_done, m_cyc, m_beats); end
    step();
  endtask

  task automatic test_slverr();
    set_defaults();
    a_tb[7] = 32'h0000_7000; l_tb[7] = 8'd0;
    k_bresp = 2'b10; k_bid = 3'd7;
    run_burst(8'h80, 0);
    vectors++; if (m_done !== 8'h80 || m_err !== 8'h80) begin miscompares++; $display("FAIL slverr got %h/%h want 80/80", m_done, m_err); end
    step();
    k_bresp = 2'b00; k_bid = 3'd2;
    run_burst(8'h80, 0);
    vectors++; if (m_done !== 8'h80 || m_err !== 8'h80) begin miscompares++; $display("FAIL bid_mismatch got %h/%h want 80/80", m_done, m_err); end
    step();
    k_bresp = 2'b01; k_bid = 3'd7;
    run_burst(8'h80, 0);
    vectors++; if (m_done !== 8'h80 || m_err !== 8'h00) begin miscompares++; $display("FAIL exokay got %h/%h want 80/00", m_done, m_err); end
    step();
  endtask

  task automatic test_ignore_grant();
    set_defaults();
    k_glitch_cyc = 3; k_glitch = 8'h04;
    a_tb[1] = 32'h0000_1100; l_tb[1] = 8'd3;
    a_tb[2] = 32'h0000_2200; l_tb[2] = 8'd0;
    run_burst(8'h02, 0);
    vectors++; if (m_done !== 8'h02 || m_cyc !== 8) begin miscompares++; $display("FAIL ignore_done got %h@%0d want 02@8", m_done, m_cyc); end
    vectors++; if (m_awids !== 8'h02 || m_beats !== 4) begin miscompares++; $display("FAIL ignore_aw got ids=%h beats=%0d want 02/4", m_awids, m_beats); end
    step();
    vectors++; if (awvalid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL ignore_idle got aw=%b busy=%b want 0/0", awvalid, busy); end
    step();
    vectors++; if (awvalid !== 1'b0 || xfer_done !== 8'h00) begin miscompares++; $display("FAIL ignore_idle2 got aw=%b done=%h want 0/00", awvalid, xfer_done); end
  endtask

  task automatic test_reset_mid();
    set_defaults();
    a_tb[0] = 32'h0000_1000; l_tb[0] = 8'd3;
    run_burst(8'h01, 2);
    @(posedge clk); #3;
    vectors++; if (wvalid !== 1'b1 || wlast !== 1'b0) begin miscompares++; $display("FAIL rstmid_pre got wvalid=%b wlast=%b want 1/0", wvalid, wlast); end
    reset = 1'b1;
    #1;
    vectors++; if (wvalid !== 1'b0 || sm_wready !== 8'h00 || wdata !== 32'h0) begin miscompares++; $display("FAIL rstmid_w got %b %h %h want 0 00 0", wvalid, sm_wready, wdata); end
    vectors++; if (busy !== 1'b0 || xfer_done !== 8'h00 || awvalid !== 1'b0 || bready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctl got %b %h %b %b want 0 00 0 0", busy, xfer_done, awvalid, bready); end
    repeat (2) begin
      step();
      vectors++; if (xfer_done !== 8'h00) begin miscompares++; $display("FAIL rstmid_nodone got %h want 00", xfer_done); end
    end
    reset = 1'b0;
    step();
    l_tb[0] = 8'd0;
    run_burst(8'h01, 0);
    vectors++; if (m_done !== 8'h01 || m_cyc !== 5 || m_beats !== 1 || m_wlast_bad) begin miscompares++; $display("FAIL rstmid_clean got %h@%0d beats=%0d want 01@5 beats=1", m_done, m_cyc, m_beats); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin a_tb[i] = 32'h0; l_tb[i] = 8'h0; end
    set_defaults();
    test_reset();
    test_basic();
    test_stall_data();
    test_aw_delay();
    test_slverr();
    test_ignore_grant();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
